conv_bf16tomx_ctrl: RTL

Streaming controller that sequences the bf16-to-MX block converter. It gathers scalar bf16 elements from a valid/ready stream into k-element blocks, issues each block to the fixed-latency converter pipeline, and captures the converter results (element vector and shared 8-bit scale). Results are buffered in an output FIFO and presented on a valid/ready interface. It sits between the activation producer and the MX compute/storage path, and is the only agent allowed to drive the converter input.

---
 rtl/conv_bf16tomx_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/conv_bf16tomx_ctrl.sv
// conv_bf16tomx_ctrl: packs a scalar bf16 stream into k-lane blocks, issues each
// block to the fixed-latency bf16->MX converter and buffers the converter results
// in a first-word-fall-through output FIFO.
// Optional build macro: CONV_CTRL_STATS_EN enables the o_stat_* counters.
module conv_bf16tomx_ctrl #(
    parameter int unsigned exp_width    = 5,
    parameter int unsigned man_width    = 2,
    parameter int unsigned k            = 32,
    parameter int unsigned conv_latency = 1,
    parameter int unsigned out_depth    = 4,
    localparam int unsigned bit_width   = 1 + exp_width + man_width
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [15:0]                 i_bf16,
    input  logic                        i_valid,
    input  logic                        i_last,
    output logic                        o_ready,
    output logic [k-1:0][15:0]          o_conv_vec,
    output logic                        o_conv_vld,
    input  logic [k-1:0][bit_width-1:0] i_mx_vec,
    input  logic [7:0]                  i_mx_exp,
    output logic [k-1:0][bit_width-1:0] o_mx_vec,
    output logic [7:0]                  o_mx_exp,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_busy,
    output logic [31:0]                 o_stat_blocks,
    output logic [31:0]                 o_stat_nan,
    output logic [31:0]                 o_stat_stall
);

    localparam int unsigned cnt_w  = (k > 1) ? $clog2(k) : 1;
    localparam int unsigned ptr_w  = (out_depth > 1) ? $clog2(out_depth) : 1;
    localparam int unsigned fcnt_w = $clog2(out_depth + 1);
    localparam int unsigned lat_w  = $clog2(conv_latency + 1);
    localparam int unsigned sum_w  = $clog2(out_depth + conv_latency + 1);

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [cnt_w-1:0]         cnt_q, cnt_d;
    logic [k-1:0][15:0]       vec_q, vec_d;
    logic                     ready_q, ready_d;
    logic                     conv_vld_q, conv_vld_d;
    logic                     busy_q, busy_d;
    logic [conv_latency-1:0]  sr_q, sr_d;
    logic                     accept, credit_d, push, pop;

    logic [k-1:0][bit_width-1:0] mem_vec_q [out_depth];
    logic [k-1:0][bit_width-1:0] mem_vec_d [out_depth];
    logic [7:0]                  mem_exp_q [out_depth];
    logic [7:0]                  mem_exp_d [out_depth];
    logic [ptr_w-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [fcnt_w-1:0]           fcnt_q, fcnt_d;
    logic                        valid_q, valid_d;
    logic [k-1:0][bit_width-1:0] head_vec_q, head_vec_d;
    logic [7:0]                  head_exp_q, head_exp_d;

    function automatic logic [lat_w-1:0] popcnt(input logic [conv_latency-1:0] v);
        logic [lat_w-1:0] n;
        n = '0;
        for (int i = 0; i < int'(conv_latency); i++) n = n + lat_w'(v[i]);
        return n;
    endfunction

    // Output FIFO: push on converter tail bit, pop on consumer handshake, registered head
    always_comb begin
        push      = sr_q[conv_latency-1];
        pop       = valid_q & i_ready;
        mem_vec_d = mem_vec_q;
        mem_exp_d = mem_exp_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fcnt_d    = fcnt_q;
        if (push) begin
            mem_vec_d[wr_ptr_q] = i_mx_vec;
            mem_exp_d[wr_ptr_q] = i_mx_exp;
            wr_ptr_d = (wr_ptr_q == ptr_w'(out_depth - 1)) ? '0 : wr_ptr_q + ptr_w'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == ptr_w'(out_depth - 1)) ? '0 : rd_ptr_q + ptr_w'(1);
        end
        if (push && !pop) begin
            fcnt_d = fcnt_q + fcnt_w'(1);
        end else if (!push && pop) begin
            fcnt_d = fcnt_q - fcnt_w'(1);
        end
        valid_d    = (fcnt_d != '0);
        head_vec_d = mem_vec_d[rd_ptr_d];
        head_exp_d = mem_exp_d[rd_ptr_d];
    end

    // Block-gathering FSM, in-flight tracking and next-cycle handshake outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        accept  = i_valid & ready_q;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    vec_d[cnt_q] = i_bf16;
                    if (i_last || (cnt_q == cnt_w'(k - 1))) begin
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        cnt_d = cnt_q + cnt_w'(1);
                    end
                end
            end
            S_ISSUE: begin
                // conv_vld_q is high exactly when the pending block is issued this cycle
                if (conv_vld_q) begin
                    vec_d   = '0;
                    cnt_d   = '0;
                    state_d = S_FILL;
                    if (accept) begin
                        vec_d[0] = i_bf16;
                        if (i_last || (k == 1)) begin
                            state_d = S_ISSUE;
                        end else begin
                            cnt_d = cnt_w'(1);
                        end
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
        sr_d       = sr_q << 1;
        sr_d[0]    = conv_vld_q;
        credit_d   = (sum_w'(fcnt_d) + sum_w'(popcnt(sr_d))) < sum_w'(out_depth);
        ready_d    = (state_d == S_FILL) || credit_d;
        conv_vld_d = (state_d == S_ISSUE) && credit_d;
        busy_d     = (cnt_d != '0) || (state_d == S_ISSUE) || (sr_d != '0) || (fcnt_d != '0);
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_FILL;
            cnt_q      <= '0;
            vec_q      <= '0;
            ready_q    <= 1'b0;
            conv_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            sr_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            valid_q    <= 1'b0;
            head_vec_q <= '0;
            head_exp_q <= '0;
            for (int i = 0; i < int'(out_depth); i++) begin
                mem_vec_q[i] <= '0;
                mem_exp_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vec_q      <= vec_d;
            ready_q    <= ready_d;
            conv_vld_q <= conv_vld_d;
            busy_q     <= busy_d;
            sr_q       <= sr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
            valid_q    <= valid_d;
            head_vec_q <= head_vec_d;
            head_exp_q <= head_exp_d;
            for (int i = 0; i < int'(out_depth); i++) begin
                mem_vec_q[i] <= mem_vec_d[i];
                mem_exp_q[i] <= mem_exp_d[i];
            end
        end
    end

    assign o_ready    = ready_q;
    assign o_conv_vec = vec_q;
    assign o_conv_vld = conv_vld_q;
    assign o_mx_vec   = head_vec_q;
    assign o_mx_exp   = head_exp_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy_q;

`ifdef CONV_CTRL_STATS_EN
    logic [31:0] stat_blocks_q, stat_blocks_d;
    logic [31:0] stat_nan_q, stat_nan_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Wrapping event counters: issued blocks, NaN-scale FIFO writes, credit stalls
    always_comb begin
        stat_blocks_d = stat_blocks_q + 32'(conv_vld_q);
        stat_nan_d    = stat_nan_q + 32'(push && (i_mx_exp == 8'hff));
        stat_stall_d  = stat_stall_q + 32'((state_q == S_ISSUE) && !conv_vld_q);
    end

    // Statistics registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stat_blocks_q <= '0;
            stat_nan_q    <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_blocks_q <= stat_blocks_d;
            stat_nan_q    <= stat_nan_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign o_stat_blocks = stat_blocks_q;
    assign o_stat_nan    = stat_nan_q;
    assign o_stat_stall  = stat_stall_q;
`else
    assign o_stat_blocks = '0;
    assign o_stat_nan    = '0;
    assign o_stat_stall  = '0;
`endif

endmodule
